// File: rtl/piano_note_sequencer.sv
// rtl/piano_note_sequencer.sv - UART key echo and square-wave note player
module piano_note_sequencer #(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int NOTE_UNIT  = CLOCK_FREQ / 20,
    parameter int TONE_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       rotary_event,
    input  logic       rotary_left,
    output logic       square_wave,
    output logic       playing,
    output logic [2:0] note_len
);

    localparam int DUR_W = $clog2(8 * NOTE_UNIT + 1);

    typedef enum logic [1:0] {IDLE, ECHO, PLAY} state_t;

    state_t             state;
    state_t             state_next;
    logic               armed;
    logic [7:0]         byte_q;
    logic [15:0]        half_q;
    logic [15:0]        half_cnt;
    logic [DUR_W-1:0]   dur_cnt;
    logic               sq_q;
    logic [2:0]         len_q;
    logic               play_start;
    logic               mapped;
    logic [15:0]        half_sel;
    logic [31:0]        dur_full;

    function automatic logic [15:0] scaled(input int hp);
        int v;
        v = hp / TONE_DIV;
        if (v < 1) v = 1;
        return 16'(v);
    endfunction

    always_comb begin
        half_sel = 16'd1;
        case (byte_q)
            8'h61:   half_sel = scaled(63066);
            8'h62:   half_sel = scaled(56187);
            8'h63:   half_sel = scaled(50056);
            8'h64:   half_sel = scaled(47247);
            8'h65:   half_sel = scaled(42092);
            8'h66:   half_sel = scaled(37500);
            8'h67:   half_sel = scaled(33409);
            8'h68:   half_sel = scaled(31534);
            default: half_sel = 16'd1;
        endcase
    end

    assign mapped   = (byte_q >= 8'h61) && (byte_q <= 8'h68);
    assign dur_full = (32'(len_q) + 32'd1) * 32'(NOTE_UNIT);

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        play_start = 1'b0;
        case (state)
            IDLE: begin
                rx_ready = armed;
                if (rx_valid && armed) state_next = ECHO;
            end
            ECHO: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = mapped ? PLAY : IDLE;
                    play_start = mapped;
                end
            end
            PLAY: begin
                if (dur_cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_next;
    end

    // armed keeps rx_ready low for the first cycle after reset releases
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            armed    <= 1'b0;
            byte_q   <= 8'h00;
            half_q   <= 16'd0;
            half_cnt <= 16'd0;
            dur_cnt  <= '0;
            sq_q     <= 1'b0;
            len_q    <= 3'd3;
        end else begin
            armed <= 1'b1;
            if (state == IDLE && rx_valid && armed) byte_q <= rx_data;
            if (play_start) begin
                half_q   <= half_sel;
                half_cnt <= half_sel - 16'd1;
                dur_cnt  <= DUR_W'(dur_full - 32'd1);
                sq_q     <= 1'b1;
            end else if (state == PLAY) begin
                if (dur_cnt == '0) begin
                    sq_q <= 1'b0;
                end else begin
                    dur_cnt <= dur_cnt - 1'b1;
                    if (half_cnt == 16'd0) begin
                        sq_q     <= ~sq_q;
                        half_cnt <= half_q - 16'd1;
                    end else begin
                        half_cnt <= half_cnt - 16'd1;
                    end
                end
            end
            if (rotary_event) begin
                if (rotary_left) begin
                    if (len_q != 3'd0) len_q <= len_q - 3'd1;
                end else begin
                    if (len_q != 3'd7) len_q <= len_q + 3'd1;
                end
            end
        end
    end

    assign tx_data     = byte_q;
    assign playing     = (state == PLAY);
    assign square_wave = sq_q;
    assign note_len    = len_q;

endmodule
